pe_feeder: RTL and testbench
============================

Name: pe_feeder

Overview:
Operand sequencer directly upstream of the serial inner-product PE.
- On one accepted command it reads a neuron vector and N_OUT weight vectors from two single-port buffers (1-cycle read latency).
- Streams one neuron/weight pair per cycle into the PE with vld and first/last ctrl flags, so the PE emits one dot product per output neuron.
- Sits between the on-chip buffers / top-level controller and the PE.

Parameters:
DW, 16, neuron/weight data width
AW, 10, buffer address width
LW, 10, vector-length field width
OW, 8, output-count field width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_n_base  in  AW  neuron vector base address
cmd_w_base  in  AW  weight matrix base address (row-major, rows contiguous)
cmd_len  in  LW  vector length L
cmd_n_out  in  OW  output neuron count N
pause  in  1  suppresses issue of new reads this cycle
nbuf_rd  out  1  neuron buffer read enable
nbuf_addr  out  AW  neuron buffer address
nbuf_rdata  in  DW  neuron data, valid cycle after nbuf_rd
wbuf_rd  out  1  weight buffer read enable
wbuf_addr  out  AW  weight buffer address
wbuf_rdata  in  DW  weight data, valid cycle after wbuf_rd
neuron  out  DW  to PE; nbuf_rdata when vld_o, else 0
weight  out  DW  to PE; wbuf_rdata when vld_o, else 0
ctrl  out  2  to PE; bit0 = first element, bit1 = last element
vld_o  out  1  to PE vld_i
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at command completion

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-low, rst_n.
- Reset values: state=IDLE; all counters 0; nbuf_rd, wbuf_rd, vld_o, ctrl, busy, done = 0; addresses 0.
- A reset asserted mid-command aborts it. The in-flight read is discarded and no vld_o or done follows.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch fields; set i=0, o=0, nptr=n_base, wptr=w_base.
  - If L==0 or N==0: enter DRAIN with an empty flag set (no reads).
  - Otherwise: enter RUN.
- RUN, each cycle with pause=0:
  - Assert nbuf_rd and wbuf_rd; nbuf_addr=nptr, wbuf_addr=wptr.
  - Record first=(i==0), last=(i==L-1) into a 1-deep issue pipe.
  - wptr+=1 every issue, wrapping mod 2^AW.
  - If i==L-1: i=0, nptr=n_base, o+=1. Otherwise: i+=1, nptr+=1.
  - On the issue with i==L-1 and o==N-1, go to DRAIN.
- RUN with pause=1: no reads; counters hold.
- DRAIN:
  - Lasts one cycle; pause is ignored. done=1.
  - The final element's vld_o/ctrl present in this same cycle (absent if the empty flag is set).
  - Next state IDLE.
- Issue-to-PE latency is exactly 1 cycle:
  - vld_o(t+1)=rd(t); ctrl(t+1)={last,first} from t.
  - Without vld_o, ctrl is 0.
- L==1: ctrl=2'b11 on every element.
- A pause gap between elements leaves vld_o=0 for those cycles. The PE partial sum holds, so a gap never corrupts a result.
- Commands are not pipelined. Minimum gap between last issue and the next accept is 2 cycles (DRAIN, IDLE).
- No arithmetic beyond counters. Address overflow wraps silently.

Decomposition:
- Shared package npu_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - constants CTRL_FIRST=0, CTRL_LAST=1 (shared with the PE);
  - default widths DW/AW.
- One natural sub-module: pe_feeder_cnt, the nested i/o loop counter emitting first, last and final flags.
- FSM, pointers and the issue pipe stay in pe_feeder.

Test Plan:
- L=4, N=2, n_base=0x010, w_base=0x100, pause=0:
  - nbuf_addr 0x10..0x13 twice; wbuf_addr 0x100..0x107 contiguous.
  - ctrl at vld_o = 01,00,00,10 per row; with a PE model, results = two correct dot products; done once, 9 cycles after accept.
- L=1, N=3: ctrl=11 on all three vld_o beats; three PE outputs equal the single products.
- L=3, N=1, pause high for 2 cycles after the 2nd issue:
  - vld_o pattern 1,1,0,0,1.
  - PE result matches the unpaused run; done follows the last beat.
- cmd_len=0 (and separately cmd_n_out=0): no rd or vld_o ever; done pulses 1 cycle after accept; cmd_ready back high the next cycle.
- rst_n low for 1 cycle in the middle of RUN (L=8, N=4, 5th issue):
  - next cycle all outputs 0, state IDLE, no done.
  - a new command then completes normally.
- w_base=0x3FE, L=4, N=1: wbuf_addr 0x3FE, 0x3FF, 0x000, 0x001 (wrap).

Source files
------------

// File: rtl/npu_pkg.sv
// Types and constants shared by the NPU datapath blocks: the feeder FSM state
// encoding, the PE ctrl bit positions, and the default datapath widths.
package npu_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned AW_DEF = 10;
  localparam int unsigned LW_DEF = 10;
  localparam int unsigned OW_DEF = 8;

  // Bit positions inside the 2-bit ctrl word sent to the PE
  localparam int unsigned CTRL_FIRST = 0;
  localparam int unsigned CTRL_LAST  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pe_feeder_if.sv
// Bundle of the feeder's command, buffer-read and PE-stream signals.
// The master modport is the feeder; the slave modport is its surroundings.
interface pe_feeder_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10,
  parameter int unsigned LW = 10,
  parameter int unsigned OW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_n_base;
  logic [AW-1:0] cmd_w_base;
  logic [LW-1:0] cmd_len;
  logic [OW-1:0] cmd_n_out;
  logic          pause;
  logic          nbuf_rd;
  logic [AW-1:0] nbuf_addr;
  logic [DW-1:0] nbuf_rdata;
  logic          wbuf_rd;
  logic [AW-1:0] wbuf_addr;
  logic [DW-1:0] wbuf_rdata;
  logic [DW-1:0] neuron;
  logic [DW-1:0] weight;
  logic [1:0]    ctrl;
  logic          vld_o;
  logic          busy;
  logic          done;

  modport master (
    input  cmd_valid, cmd_n_base, cmd_w_base, cmd_len, cmd_n_out, pause,
           nbuf_rdata, wbuf_rdata,
    output cmd_ready, nbuf_rd, nbuf_addr, wbuf_rd, wbuf_addr,
           neuron, weight, ctrl, vld_o, busy, done
  );

  modport slave (
    output cmd_valid, cmd_n_base, cmd_w_base, cmd_len, cmd_n_out, pause,
           nbuf_rdata, wbuf_rdata,
    input  cmd_ready, nbuf_rd, nbuf_addr, wbuf_rd, wbuf_addr,
           neuron, weight, ctrl, vld_o, busy, done
  );

endinterface

// File: rtl/pe_feeder_cnt.sv
// Nested element (i) / output-row (o) loop counter for the feeder.
// Flags first/last element of the current row and the final element of the command.
module pe_feeder_cnt
  import npu_pkg::*;
#(
  parameter int unsigned LW = LW_DEF,
  parameter int unsigned OW = OW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          adv,
  input  logic [LW-1:0] len,
  input  logic [OW-1:0] n_out,
  output logic          first,
  output logic          last,
  output logic          fin
);

  logic [LW-1:0] i;
  logic [LW-1:0] len_q;
  logic [OW-1:0] o;
  logic [OW-1:0] n_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i       <= '0;
      o       <= '0;
      len_q   <= '0;
      n_out_q <= '0;
    end else if (start) begin
      i       <= '0;
      o       <= '0;
      len_q   <= len;
      n_out_q <= n_out;
    end else if (adv) begin
      if (last) begin
        i <= '0;
        o <= o + OW'(1);
      end else begin
        i <= i + LW'(1);
      end
    end
  end

  assign first = (i == '0);
  assign last  = (i == LW'(len_q - LW'(1)));
  assign fin   = last && (o == OW'(n_out_q - OW'(1)));

endmodule

// File: rtl/pe_feeder.sv
// Operand sequencer for the serial inner-product PE: walks a neuron vector
// against N_OUT weight rows and streams one operand pair per cycle with first/last flags.
module pe_feeder
  import npu_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned LW = LW_DEF,
  parameter int unsigned OW = OW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  pe_feeder_if.master  bus
);

  state_t        state;
  logic [AW-1:0] nptr;
  logic [AW-1:0] wptr;
  logic [AW-1:0] n_base_q;
  logic          vld_q;
  logic [1:0]    ctrl_q;
  logic [1:0]    ctrl_nxt;
  logic          first;
  logic          last;
  logic          fin;
  logic          start;
  logic          issue;
  logic          empty;

  assign start = (state == IDLE) && bus.cmd_valid;
  assign issue = (state == RUN) && !bus.pause;
  assign empty = (bus.cmd_len == '0) || (bus.cmd_n_out == '0);

  pe_feeder_cnt #(.LW(LW), .OW(OW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .adv   (issue),
    .len   (bus.cmd_len),
    .n_out (bus.cmd_n_out),
    .first (first),
    .last  (last),
    .fin   (fin)
  );

  always_comb begin
    ctrl_nxt             = '0;
    ctrl_nxt[CTRL_FIRST] = first;
    ctrl_nxt[CTRL_LAST]  = last;
  end

  // FSM, read pointers and the 1-deep issue pipe toward the PE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      nptr     <= '0;
      wptr     <= '0;
      n_base_q <= '0;
      vld_q    <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      vld_q  <= issue;
      ctrl_q <= issue ? ctrl_nxt : 2'b00;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            n_base_q <= bus.cmd_n_base;
            nptr     <= bus.cmd_n_base;
            wptr     <= bus.cmd_w_base;
            state    <= empty ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            wptr <= wptr + AW'(1);
            nptr <= last ? n_base_q : nptr + AW'(1);
            if (fin) state <= DRAIN;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.done      = (state == DRAIN);
  assign bus.nbuf_rd   = issue;
  assign bus.wbuf_rd   = issue;
  assign bus.nbuf_addr = nptr;
  assign bus.wbuf_addr = wptr;
  assign bus.vld_o     = vld_q;
  assign bus.ctrl      = ctrl_q;
  // Buffer data arrives with the vld beat; gate it so the PE sees 0 otherwise
  assign bus.neuron    = vld_q ? bus.nbuf_rdata : '0;
  assign bus.weight    = vld_q ? bus.wbuf_rdata : '0;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: buffer models, a small PE accumulator model,
// a command table with hand-computed results, plus a mid-command reset sequence.
module tb_pe_feeder;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 10;
  localparam int unsigned OW = 8;

  logic clk;
  logic rst_n;
  int   nchk;
  int   nfail;

  pe_feeder_if #(.DW(DW), .AW(AW), .LW(LW), .OW(OW)) bus ();

  pe_feeder #(.DW(DW), .AW(AW), .LW(LW), .OW(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffers: neuron[a] = a[7:0], weight[a] = a[3:0] + 1, one-cycle read latency
  always @(posedge clk) begin
    if (bus.nbuf_rd) bus.nbuf_rdata <= 16'(bus.nbuf_addr[7:0]);
    if (bus.wbuf_rd) bus.wbuf_rdata <= 16'(bus.wbuf_addr[3:0]) + 16'd1;
  end

  typedef struct {
    logic [9:0]  n_base;
    logic [9:0]  w_base;
    logic [9:0]  len;
    logic [7:0]  n_out;
    int          pause_after;
    int          pause_len;
    int          exp_lat;
    int          exp_iss;
    int          exp_nres;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] exp_vld;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(input logic [9:0] nb, input logic [9:0] wb,
                              input logic [9:0] len, input logic [7:0] nout,
                              input int pa, input int pl, input int lat,
                              input int iss, input int nres,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] vp);
    vec_t v;
    v.n_base = nb; v.w_base = wb; v.len = len; v.n_out = nout;
    v.pause_after = pa; v.pause_len = pl; v.exp_lat = lat;
    v.exp_iss = iss; v.exp_nres = nres;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.exp_vld = vp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_cmd(input logic [9:0] nb, input logic [9:0] wb,
                           input logic [9:0] len, input logic [7:0] nout);
    bus.cmd_valid  = 1'b1;
    bus.cmd_n_base = nb;
    bus.cmd_w_base = wb;
    bus.cmd_len    = len;
    bus.cmd_n_out  = nout;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          cyc;
    int          n_iss;
    int          n_beat;
    int          n_res;
    int          paused;
    int          done_cyc;
    int          k;
    logic [31:0] acc;
    logic [31:0] prod;
    logic [31:0] res[3];
    logic [31:0] hist;
    logic [1:0]  exp_ctrl;
    cyc = 0; n_iss = 0; n_beat = 0; n_res = 0; paused = 0; done_cyc = -1;
    acc = '0; hist = '0;
    foreach (res[j]) res[j] = '0;
    @(posedge clk); #1;
    bus.pause = 1'b0;
    drive_cmd(v.n_base, v.w_base, v.len, v.n_out);
    @(negedge clk);
    chk({nm, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({nm, "_idle_neuron"}, 32'(bus.neuron), 32'd0);
    while (done_cyc < 0 && cyc < 200) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      cyc++;
      bus.pause = (v.pause_after >= 0) && (n_iss >= v.pause_after) && (paused < v.pause_len);
      if (bus.pause) paused++;
      @(negedge clk);
      hist = {hist[30:0], bus.vld_o};
      if (bus.nbuf_rd) begin
        chk({nm, "_naddr"}, 32'(bus.nbuf_addr),
            32'((int'(v.n_base) + n_iss % int'(v.len)) & 'h3FF));
        chk({nm, "_waddr"}, 32'(bus.wbuf_addr), 32'((int'(v.w_base) + n_iss) & 'h3FF));
        chk({nm, "_wrd"}, 32'(bus.wbuf_rd), 32'd1);
        n_iss++;
      end
      if (bus.vld_o) begin
        k = n_beat % int'(v.len);
        exp_ctrl = {k == int'(v.len) - 1, k == 0};
        chk({nm, "_ctrl"}, 32'(bus.ctrl), 32'(exp_ctrl));
        prod = 32'(bus.neuron) * 32'(bus.weight);
        acc  = bus.ctrl[0] ? prod : acc + prod;
        if (bus.ctrl[1]) begin
          if (n_res < 3) res[n_res] = acc;
          n_res++;
        end
        n_beat++;
      end else begin
        chk({nm, "_ctrl_idle"}, 32'(bus.ctrl), 32'd0);
      end
      if (bus.done) done_cyc = cyc;
    end
    bus.pause = 1'b0;
    if (done_cyc < 0) begin
      nchk++; nfail++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
    chk({nm, "_lat"}, 32'(done_cyc), 32'(v.exp_lat));
    chk({nm, "_issues"}, 32'(n_iss), 32'(v.exp_iss));
    chk({nm, "_nres"}, 32'(n_res), 32'(v.exp_nres));
    if (v.exp_nres > 0) chk({nm, "_res0"}, res[0], v.r0);
    if (v.exp_nres > 1) chk({nm, "_res1"}, res[1], v.r1);
    if (v.exp_nres > 2) chk({nm, "_res2"}, res[2], v.r2);
    chk({nm, "_vld_pat"}, hist, v.exp_vld);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({nm, "_ready_after"}, 32'(bus.cmd_ready), 32'd1);
    chk({nm, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic reset_mid_run();
    int   n_iss;
    int   guard;
    logic bad;
    n_iss = 0; guard = 0; bad = 1'b0;
    @(posedge clk); #1;
    drive_cmd(10'h000, 10'h000, 10'd8, 8'd4);
    while (n_iss < 5 && guard < 50) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      guard++;
      @(negedge clk);
      if (bus.nbuf_rd) n_iss++;
      if (bus.done) bad = 1'b1;
      if (n_iss == 5) rst_n = 1'b0;
    end
    chk("rst_reached_5th", 32'(n_iss), 32'd5);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vld", 32'(bus.vld_o), 32'd0);
    chk("rst_ctrl", 32'(bus.ctrl), 32'd0);
    chk("rst_rd", 32'({bus.nbuf_rd, bus.wbuf_rd}), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_addr", 32'({bus.nbuf_addr, bus.wbuf_addr}), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.vld_o || bus.done || bus.nbuf_rd) bad = 1'b1;
    end
    chk("rst_quiet", 32'(bad), 32'd0);
  endtask

  initial begin
    nchk = 0; nfail = 0;
    rst_n = 1'b0;
    bus.pause = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_n_base = '0; bus.cmd_w_base = '0; bus.cmd_len = '0; bus.cmd_n_out = '0;
    //              n_base   w_base   len    n_out pa  pl lat iss nres r0      r1      r2      vld
    tbl[0] = mk(10'h010, 10'h100, 10'd4, 8'd2, -1, 0, 9,  8, 2, 32'd180, 32'd460, 32'd0,  32'h0FF);
    tbl[1] = mk(10'h020, 10'h200, 10'd1, 8'd3, -1, 0, 4,  3, 3, 32'd32,  32'd64,  32'd96, 32'h007);
    tbl[2] = mk(10'h005, 10'h108, 10'd3, 8'd1,  2, 2, 6,  3, 1, 32'd182, 32'd0,   32'd0,  32'h019);
    tbl[3] = mk(10'h010, 10'h100, 10'd0, 8'd3, -1, 0, 1,  0, 0, 32'd0,   32'd0,   32'd0,  32'h000);
    tbl[4] = mk(10'h010, 10'h100, 10'd5, 8'd0, -1, 0, 1,  0, 0, 32'd0,   32'd0,   32'd0,  32'h000);
    tbl[5] = mk(10'h001, 10'h3FE, 10'd4, 8'd1, -1, 0, 5,  4, 1, 32'd58,  32'd0,   32'd0,  32'h00F);
    tbl[6] = mk(10'h040, 10'h000, 10'd2, 8'd2, -1, 0, 5,  4, 2, 32'd194, 32'd452, 32'd0,  32'h00F);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_vld", 32'(bus.vld_o), 32'd0);
    chk("reset_done_busy", 32'({bus.done, bus.busy}), 32'd0);
    chk("reset_rd", 32'({bus.nbuf_rd, bus.wbuf_rd}), 32'd0);
    chk("reset_ctrl", 32'(bus.ctrl), 32'd0);
    chk("reset_addr", 32'({bus.nbuf_addr, bus.wbuf_addr}), 32'd0);
    chk("reset_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (i == 6) reset_mid_run();
      run_vec(tbl[i], $sformatf("v%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
